vend_dispenser: RTL
===================

# vend_dispenser

Mechanical back end of the vending machine. Consumes the controller's one-cycle `out` (release product) and `change` (coins to return) outputs, then sequences the product solenoid and coin hopper with timed drive pulses. Each drive pulse is confirmed by a drop sensor, with timeout-to-fault protection. A one-deep pending buffer absorbs a request that arrives while a sequence is in progress.

## Interface
- `SOL_CYCLES`, default 8: solenoid on-time in clocks, 1..255.
- `HOP_CYCLES`, default 4: hopper eject pulse width in clocks, 1..255.
- `TIMEOUT`, default 64: maximum clocks to wait for a sensor after a drive pulse, 1..1023.

- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `out`, input, 1: product release request from the controller.
- `change`, input, 2: number of coins to return, 0..3.
- `prod_sense`, input, 1: product drop sensor, synchronous, active-high.
- `coin_sense`, input, 1: coin exit sensor, synchronous, active-high.
- `prod_sol`, output, 1: product solenoid drive.
- `hopper_pulse`, output, 1: hopper eject drive.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when a request completes successfully.
- `fault`, output, 1: sticky. Set on sensor timeout or pending overflow.

## Operation
- **Request.** A request is sampled on any edge where `out | (change != 0)`. It is stored as {vend = `out`, coins = `change`}.
- **Pending buffer.**
  - In IDLE with the pending buffer empty, a request is taken directly.
  - While busy, a request goes to the one-entry pending buffer.
  - A request while busy with the pending buffer full is dropped and sets `fault`.
- **States:** IDLE, VEND, VEND_WAIT, COIN, COIN_WAIT, FAULT.
- **IDLE:**
  - Start from the pending buffer if it is full, otherwise from a new request.
  - Go to VEND if vend=1, otherwise to COIN if coins>0.
- **VEND:** `prod_sol`=1 for exactly SOL_CYCLES cycles, then VEND_WAIT.
- **VEND_WAIT:** `prod_sol`=0. Leave when the sensor is confirmed:
  - go to COIN if coins>0, otherwise to IDLE with a `done` pulse.
- **COIN:** `hopper_pulse`=1 for exactly HOP_CYCLES cycles, then COIN_WAIT.
- **COIN_WAIT:** Leave when the sensor is confirmed:
  - decrement coins;
  - go to COIN if coins are still >0, otherwise to IDLE with a `done` pulse.
- **Sensor latching.** A sensor high in any cycle of its drive state or wait state is latched. The latch is cleared on each new drive state entry. A sensor latched during the drive state causes exit in the first wait cycle.
- **Timeout.** If the wait counter reaches TIMEOUT without a latched sensor, go to FAULT.
- **FAULT:**
  - All drives are 0, `busy`=1, `fault`=1.
  - New requests are ignored and the pending buffer is held.
  - Exit only by reset.
- **Overflow during a sequence.** An overflow `fault` raised during a sequence does not stop that sequence. After the sequence finishes, the FSM enters FAULT instead of IDLE.
- **Guard.** `prod_sol` and `hopper_pulse` are never high in the same cycle.

## Timing
- **Reset (asynchronous, active-low):**
  - all outputs are 0 and the state is IDLE;
  - the pending buffer and counters are cleared;
  - the sensor latch is cleared;
  - this holds mid-sequence: drives drop in the same cycle `reset` falls.
- **Start latency.** Request on edge N gives `prod_sol` (or `hopper_pulse`) high from edge N+1.
- **Minimum time per item.** Drive phase plus 1 wait cycle: SOL_CYCLES+1 for the product, HOP_CYCLES+1 per coin.
- **done.** High for the single cycle after the edge that enters IDLE.
- **Pending start.** A pending request starts on the edge after `done`, giving one IDLE cycle between sequences.
- **Simultaneous events.** A request arriving on the same edge that a sequence completes goes into the pending buffer, not a direct start.
- **Wait counter.** Counts 1..TIMEOUT. Timeout fires on the edge where the count equals TIMEOUT and no sensor is latched.

## Configuration
- **`VEND_DISPENSE_RETRY_EN` defined:**
  - on the first timeout of a given item, re-enter its drive state once, with the wait counter and latch cleared;
  - a second timeout on the same item goes to FAULT;
  - the retry flag resets per item.
- **Not defined:** the first timeout goes to FAULT. The retry logic is absent.

## Test plan
- **Product only.** Defaults, `out`=1 for one cycle, `prod_sense` pulsed 3 cycles after `prod_sol` falls. Required: `prod_sol` high for 8 cycles, `done` pulses once, `hopper_pulse` never asserts.
- **Vend plus change.** `out`=1 with `change`=2, each sensor returned 2 cycles into its wait. Required:
  - 8-cycle `prod_sol`, then two 4-cycle `hopper_pulse` bursts;
  - drives never overlap;
  - a single `done` at the end.
- **Pending buffer.**
  - Second request (`change`=1) while busy: it runs after `done` with one IDLE gap.
  - Third request while busy with the buffer full: `fault`=1, and FAULT is entered after the current sequence.
- **Timeout.** `out`=1 and `prod_sense` held low:
  - without the macro, FAULT is entered 64 cycles after `prod_sol` falls;
  - with `VEND_DISPENSE_RETRY_EN`, a second 8-cycle `prod_sol` burst follows, then FAULT.
- **Reset mid-sequence.** `reset` driven low during the second `hopper_pulse`. Required:
  - all outputs go to 0 immediately;
  - after release, the block is IDLE with an empty buffer;
  - a new `out`=1 starts normally.

Source files
------------

// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispenser
// Description : Mechanical back end of the vending machine. Takes one-cycle
//               release/change requests, drives the product solenoid and the
//               coin hopper with timed pulses, confirms each item with its
//               drop sensor, and faults on sensor timeout or when a request
//               arrives with the one-deep pending buffer already full.
//               Optional feature macro: VEND_DISPENSE_RETRY_EN (one re-drive
//               per item before a timeout becomes a fault).
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispenser #(
    parameter int SOL_CYCLES = 8,
    parameter int HOP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       out,
    input  logic [1:0] change,
    input  logic       prod_sense,
    input  logic       coin_sense,
    output logic       prod_sol,
    output logic       hopper_pulse,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_VEND      = 3'd1;
    localparam logic [2:0] c_VEND_WAIT = 3'd2;
    localparam logic [2:0] c_COIN      = 3'd3;
    localparam logic [2:0] c_COIN_WAIT = 3'd4;
    localparam logic [2:0] c_FAULT     = 3'd5;

    localparam logic [7:0] c_SOL_LAST = 8'(SOL_CYCLES - 1);
    localparam logic [7:0] c_HOP_LAST = 8'(HOP_CYCLES - 1);
    localparam logic [9:0] c_TIMEOUT  = 10'(TIMEOUT);

    logic [2:0] r_state;
    logic [1:0] r_coins;
    logic       r_pend_vld;
    logic       r_pend_vend;
    logic [1:0] r_pend_coins;
    logic [7:0] r_dcnt;
    logic [9:0] r_wcnt;
    logic       r_latch;
    logic       r_done;
    logic       r_fault;
`ifdef VEND_DISPENSE_RETRY_EN
    logic       r_retried;
`endif

    logic       w_req;
    logic       w_busy;
    logic       w_src_vend;
    logic [1:0] w_src_coins;
    logic       w_sense;
    logic       w_confirm;
    logic       w_ovf;
    logic       w_end_fault;
    logic [1:0] w_coins_dec;

    assign w_req       = out | (change != 2'd0);
    assign w_busy      = (r_state != c_IDLE);
    // The pending request always has priority over a new one when starting.
    assign w_src_vend  = r_pend_vld ? r_pend_vend  : out;
    assign w_src_coins = r_pend_vld ? r_pend_coins : change;
    assign w_sense     = (r_state == c_VEND_WAIT) ? prod_sense : coin_sense;
    // A sensor pulse seen during the drive phase counts on the first wait cycle.
    assign w_confirm   = r_latch | w_sense;
    assign w_ovf       = w_busy && (r_state != c_FAULT) && w_req && r_pend_vld;
    // An overflow on the very edge a sequence ends still diverts it to FAULT.
    assign w_end_fault = r_fault | w_ovf;
    assign w_coins_dec = r_coins - 2'd1;

    // Main sequencer: drive phases, sensor waits, timeout and fault entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_coins   <= 2'd0;
            r_dcnt    <= 8'd0;
            r_wcnt    <= 10'd0;
            r_latch   <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
`ifdef VEND_DISPENSE_RETRY_EN
            r_retried <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_ovf) begin
                r_fault <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (r_pend_vld || w_req) begin
                        r_coins   <= w_src_coins;
                        r_dcnt    <= 8'd0;
                        r_latch   <= 1'b0;
`ifdef VEND_DISPENSE_RETRY_EN
                        r_retried <= 1'b0;
`endif
                        r_state   <= w_src_vend ? c_VEND : c_COIN;
                    end
                end
                c_VEND: begin
                    r_latch <= r_latch | prod_sense;
                    if (r_dcnt == c_SOL_LAST) begin
                        r_state <= c_VEND_WAIT;
                        r_wcnt  <= 10'd1;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
                end
                c_VEND_WAIT: begin
                    if (w_confirm) begin
`ifdef VEND_DISPENSE_RETRY_EN
                        r_retried <= 1'b0;
`endif
                        if (r_coins != 2'd0) begin
                            r_state <= c_COIN;
                            r_dcnt  <= 8'd0;
                            r_latch <= 1'b0;
                        end else if (w_end_fault) begin
                            r_state <= c_FAULT;
                        end else begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_wcnt == c_TIMEOUT) begin
`ifdef VEND_DISPENSE_RETRY_EN
                        if (!r_retried) begin
                            r_retried <= 1'b1;
                            r_state   <= c_VEND;
                            r_dcnt    <= 8'd0;
                            r_latch   <= 1'b0;
                        end else begin
                            r_state <= c_FAULT;
                            r_fault <= 1'b1;
                        end
`else
                        r_state <= c_FAULT;
                        r_fault <= 1'b1;
`endif
                    end else begin
                        r_wcnt <= r_wcnt + 10'd1;
                    end
                end
                c_COIN: begin
                    r_latch <= r_latch | coin_sense;
                    if (r_dcnt == c_HOP_LAST) begin
                        r_state <= c_COIN_WAIT;
                        r_wcnt  <= 10'd1;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
                end
                c_COIN_WAIT: begin
                    if (w_confirm) begin
                        r_coins <= w_coins_dec;
`ifdef VEND_DISPENSE_RETRY_EN
                        r_retried <= 1'b0;
`endif
                        if (r_coins > 2'd1) begin
                            r_state <= c_COIN;
                            r_dcnt  <= 8'd0;
                            r_latch <= 1'b0;
                        end else if (w_end_fault) begin
                            r_state <= c_FAULT;
                        end else begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_wcnt == c_TIMEOUT) begin
`ifdef VEND_DISPENSE_RETRY_EN
                        if (!r_retried) begin
                            r_retried <= 1'b1;
                            r_state   <= c_COIN;
                            r_dcnt    <= 8'd0;
                            r_latch   <= 1'b0;
                        end else begin
                            r_state <= c_FAULT;
                            r_fault <= 1'b1;
                        end
`else
                        r_state <= c_FAULT;
                        r_fault <= 1'b1;
`endif
                    end else begin
                        r_wcnt <= r_wcnt + 10'd1;
                    end
                end
                c_FAULT: begin
                    r_state <= c_FAULT;
                end
                default: begin
                    r_state <= c_FAULT;
                end
            endcase
        end
    end

    // One-deep pending buffer: filled while busy, drained by the IDLE start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_vld   <= 1'b0;
            r_pend_vend  <= 1'b0;
            r_pend_coins <= 2'd0;
        end else if (r_state == c_IDLE) begin
            if (r_pend_vld) begin
                r_pend_vld   <= w_req;
                r_pend_vend  <= out;
                r_pend_coins <= change;
            end
        end else if ((r_state != c_FAULT) && w_req && !r_pend_vld) begin
            r_pend_vld   <= 1'b1;
            r_pend_vend  <= out;
            r_pend_coins <= change;
        end
    end

    // Drives decode straight from state, so they can never overlap and drop
    // in the same cycle the asynchronous reset asserts.
    assign prod_sol     = (r_state == c_VEND);
    assign hopper_pulse = (r_state == c_COIN);
    assign busy         = w_busy;
    assign done         = r_done;
    assign fault        = r_fault;

endmodule
`default_nettype wire
